// File: rtl/branch_predictor_table_if.sv
// Branch predictor port bundle: resolved-branch updates, fetch lookups and
// registered predictions. The master is the pipeline, the slave the table.
interface branch_predictor_table_if;
    logic        br_valid;
    logic [31:0] br_pc;
    logic [31:0] br_target_pc;
    logic        br_taken;
    logic        br_is_branch;
    logic        br_is_call;
    logic        br_is_return;
    logic        fetch_valid;
    logic [31:0] fetch_pc;
    logic        pred_valid;
    logic        pred_hit;
    logic        pred_taken;
    logic        pred_is_call;
    logic        pred_is_return;
    logic [31:0] pred_target;

    modport master (
        output br_valid, br_pc, br_target_pc, br_taken,
               br_is_branch, br_is_call, br_is_return,
               fetch_valid, fetch_pc,
        input  pred_valid, pred_hit, pred_taken, pred_is_call,
               pred_is_return, pred_target
    );

    modport slave (
        input  br_valid, br_pc, br_target_pc, br_taken,
               br_is_branch, br_is_call, br_is_return,
               fetch_valid, fetch_pc,
        output pred_valid, pred_hit, pred_taken, pred_is_call,
               pred_is_return, pred_target
    );
endinterface

// File: rtl/branch_predictor_table.sv
// Direct-mapped branch target table with 2-bit saturating counters.
// Lookups are registered and read the pre-update state; a flush runs a
// one-index-per-cycle invalidation sweep during which the table is inert.
module branch_predictor_table #(
    parameter int ENTRIES = 64,
    parameter int TAG_W   = 12
) (
    input  logic                      clk,
    input  logic                      rst,
    branch_predictor_table_if.slave   bp,
    input  logic                      bp_flush,
    output logic                      bp_busy
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ENTRIES - 1);

    typedef enum logic {READY, CLEAR} state_e;

    state_e           state_q;
    logic [IDX_W-1:0] clr_idx_q;

    // valid and counters are reset; payload fields are only visible behind valid
    logic [ENTRIES-1:0] valid_q;
    logic [1:0]         ctr_q [ENTRIES];
    logic [TAG_W-1:0]   tag_q [ENTRIES];
    logic [31:0]        tgt_q [ENTRIES];
    logic [2:0]         cls_q [ENTRIES];   // {is_return, is_call, is_branch}

    logic        pred_valid_q, pred_hit_q, pred_taken_q;
    logic        pred_call_q, pred_ret_q;
    logic [31:0] pred_tgt_q;

    logic [IDX_W-1:0] f_idx, u_idx, clr_cur;
    logic [TAG_W-1:0] f_tag, u_tag;
    logic             f_hit, u_hit, upd_en, alloc, wr_fields;
    logic [1:0]       ctr_d;
    logic             unused;

    // pc[1:0] and bits above the tag never take part in indexing or matching
    assign unused = ^{bp.fetch_pc, bp.br_pc};

    assign f_idx = bp.fetch_pc[IDX_W+1:2];
    assign f_tag = bp.fetch_pc[IDX_W+2 +: TAG_W];
    assign u_idx = bp.br_pc[IDX_W+1:2];
    assign u_tag = bp.br_pc[IDX_W+2 +: TAG_W];

    assign f_hit     = (state_q == READY) && valid_q[f_idx] && (tag_q[f_idx] == f_tag);
    assign u_hit     = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
    assign upd_en    = bp.br_valid && (state_q == READY);
    assign alloc     = upd_en && !u_hit && bp.br_taken;
    assign wr_fields = upd_en && bp.br_taken;

    // A flush seen mid-sweep restarts at index 0 in that same cycle
    assign clr_cur = bp_flush ? '0 : clr_idx_q;
    assign bp_busy = (state_q == CLEAR);

    // Next counter value: fresh allocations start weakly taken
    always_comb begin
        ctr_d = 2'd2;
        if (u_hit) begin
            if (bp.br_taken) ctr_d = (ctr_q[u_idx] == 2'd3) ? 2'd3 : ctr_q[u_idx] + 2'd1;
            else             ctr_d = (ctr_q[u_idx] == 2'd0) ? 2'd0 : ctr_q[u_idx] - 2'd1;
        end
    end

    // READY/CLEAR sweep controller
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= READY;
            clr_idx_q <= '0;
        end else begin
            case (state_q)
                READY: if (bp_flush) begin
                    state_q   <= CLEAR;
                    clr_idx_q <= '0;
                end
                CLEAR: if (clr_cur == LAST_IDX) begin
                    state_q   <= READY;
                    clr_idx_q <= '0;
                end else begin
                    clr_idx_q <= clr_cur + 1'b1;
                end
                default: state_q <= READY;
            endcase
        end
    end

    // Valid bits and counters: sweep invalidation, allocation, training
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
            for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= 2'd0;
        end else begin
            if (state_q == CLEAR)  valid_q[clr_cur] <= 1'b0;
            else if (alloc)        valid_q[u_idx]   <= 1'b1;
            if (u_hit && upd_en || alloc) ctr_q[u_idx] <= ctr_d;
        end
    end

    // Payload storage: target/class refresh on any taken update, tag on allocate
    always_ff @(posedge clk) begin
        if (wr_fields) begin
            tgt_q[u_idx] <= bp.br_target_pc;
            cls_q[u_idx] <= {bp.br_is_return, bp.br_is_call, bp.br_is_branch};
            if (alloc) tag_q[u_idx] <= u_tag;
        end
    end

    // Registered prediction from the pre-update table contents
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pred_valid_q <= 1'b0;
            pred_hit_q   <= 1'b0;
            pred_taken_q <= 1'b0;
            pred_call_q  <= 1'b0;
            pred_ret_q   <= 1'b0;
            pred_tgt_q   <= '0;
        end else begin
            pred_valid_q <= bp.fetch_valid;
            pred_hit_q   <= f_hit;
            pred_taken_q <= f_hit && (ctr_q[f_idx][1] || !cls_q[f_idx][0]);
            pred_call_q  <= f_hit && cls_q[f_idx][1];
            pred_ret_q   <= f_hit && cls_q[f_idx][2];
            pred_tgt_q   <= f_hit ? tgt_q[f_idx] : 32'd0;
        end
    end

    assign bp.pred_valid     = pred_valid_q;
    assign bp.pred_hit       = pred_hit_q;
    assign bp.pred_taken     = pred_taken_q;
    assign bp.pred_is_call   = pred_call_q;
    assign bp.pred_is_return = pred_ret_q;
    assign bp.pred_target    = pred_tgt_q;
endmodule
